// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: funct3 conditions and FSM states.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic logic misalign_chk(input logic taken, input logic tgt_bit1);
    return taken & tgt_bit1;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator for the six RV conditional branches.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            cond_true
);

  // Reserved encodings 010/011 fall through to not-taken.
  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = (src1 == src2);
      F3_BNE:  cond_true = (src1 != src2);
      F3_BLT:  cond_true = ($signed(src1) <  $signed(src2));
      F3_BGE:  cond_true = ($signed(src1) >= $signed(src2));
      F3_BLTU: cond_true = (src1 <  src2);
      F3_BGEU: cond_true = (src1 >= src2);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/JAL/JALR resolver with a valid/ready result port toward fetch.
// Optional performance counters are enabled with BRANCH_RESOLVE_PERF_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BRANCH_RESOLVE_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_resolved,
  output logic [CNT_W-1:0] perf_taken,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_b,
  input  logic             is_j,
  input  logic             is_jr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic             redir_taken,
  output logic [XLEN-1:0]  redir_target,
  output logic             redir_misalign
);

  state_e          state_q;
  logic            is_b_q, is_j_q, is_jr_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] src1_q, src2_q, pc_q, imm_q;
  logic            valid_q, taken_q, misalign_q;
  logic [XLEN-1:0] target_q;

  logic            cond_true_s;
  logic            taken_d, misalign_d;
  logic [XLEN-1:0] target_d, jr_sum_s;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3   (funct3_q),
    .src1     (src1_q),
    .src2     (src2_q),
    .cond_true(cond_true_s)
  );

  assign jr_sum_s = src1_q + imm_q;

  // Result from the captured operands; jr > j > b priority.
  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_q + XLEN'(4);
    if (is_jr_q) begin
      taken_d  = 1'b1;
      target_d = jr_sum_s & {{(XLEN-1){1'b1}}, 1'b0};
    end else if (is_j_q || (is_b_q && cond_true_s)) begin
      taken_d  = 1'b1;
      target_d = pc_q + imm_q;
    end else begin
      taken_d  = 1'b0;
      target_d = pc_q + XLEN'(4);
    end
    if (IALIGN == 32) begin
      misalign_d = misalign_chk(taken_d, target_d[1]);
    end else begin
      misalign_d = 1'b0;
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_b_q     <= 1'b0;
      is_j_q     <= 1'b0;
      is_jr_q    <= 1'b0;
      funct3_q   <= 3'b000;
      src1_q     <= '0;
      src2_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            is_b_q   <= is_b;
            is_j_q   <= is_j;
            is_jr_q  <= is_jr;
            funct3_q <= funct3;
            src1_q   <= src1;
            src2_q   <= src2;
            pc_q     <= pc;
            imm_q    <= imm;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          taken_q    <= taken_d;
          target_q   <= target_d;
          misalign_q <= misalign_d;
          valid_q    <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (redir_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign redir_valid    = valid_q;
  assign redir_taken    = taken_q;
  assign redir_target   = target_q;
  assign redir_misalign = misalign_q;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [CNT_W-1:0] resolved_q, taken_cnt_q;
  logic             hs_s;

  assign hs_s = (state_q == OUT) && redir_ready;

  // Saturating handshake counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolved_q  <= '0;
      taken_cnt_q <= '0;
    end else if (perf_clr) begin
      resolved_q  <= '0;
      taken_cnt_q <= '0;
    end else if (hs_s) begin
      if (resolved_q != {CNT_W{1'b1}}) resolved_q <= resolved_q + CNT_W'(1);
      if (taken_q && (taken_cnt_q != {CNT_W{1'b1}})) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign perf_resolved = resolved_q;
  assign perf_taken    = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit (IALIGN 32 and 16 instances).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, redir_ready;
  logic        is_b, is_j, is_jr;
  logic [2:0]  funct3;
  logic [31:0] src1, src2, pc, imm;

  logic        req_ready, redir_valid, redir_taken, redir_misalign;
  logic [31:0] redir_target;
  logic        req_ready16, redir_valid16, redir_taken16, redir_misalign16;
  logic [31:0] redir_target16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_resolved, perf_taken, perf_resolved16, perf_taken16;
`endif

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
`ifdef BRANCH_RESOLVE_PERF_EN
    .perf_clr(perf_clr), .perf_resolved(perf_resolved), .perf_taken(perf_taken),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .is_b(is_b), .is_j(is_j), .is_jr(is_jr), .funct3(funct3),
    .src1(src1), .src2(src2), .pc(pc), .imm(imm),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_taken(redir_taken),
    .redir_target(redir_target), .redir_misalign(redir_misalign)
  );

  branch_resolve_unit #(.XLEN(32), .IALIGN(16), .CNT_W(32)) u_dut16 (
    .clk(clk), .rst(rst),
`ifdef BRANCH_RESOLVE_PERF_EN
    .perf_clr(perf_clr), .perf_resolved(perf_resolved16), .perf_taken(perf_taken16),
`endif
    .req_valid(req_valid), .req_ready(req_ready16),
    .is_b(is_b), .is_j(is_j), .is_jr(is_jr), .funct3(funct3),
    .src1(src1), .src2(src2), .pc(pc), .imm(imm),
    .redir_valid(redir_valid16), .redir_ready(redir_ready), .redir_taken(redir_taken16),
    .redir_target(redir_target16), .redir_misalign(redir_misalign16)
  );

  typedef struct {
    string       name;
    logic        b, j, jr;
    logic [2:0]  f3;
    logic [31:0] s1, s2, pc, imm;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    is_b = v.b; is_j = v.j; is_jr = v.jr; funct3 = v.f3;
    src1 = v.s1; src2 = v.s2; pc = v.pc; imm = v.imm;
  endtask

  // One full transaction with redir_ready held high; called at a negedge.
  task automatic send(input vec_t v);
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({v.name, "_eval_rdy"}, {31'd0, req_ready}, 32'd0);
    chk({v.name, "_eval_vld"}, {31'd0, redir_valid}, 32'd0);
    @(negedge clk);
    chk({v.name, "_vld"}, {31'd0, redir_valid}, 32'd1);
    chk({v.name, "_taken"}, {31'd0, redir_taken}, {31'd0, v.exp_taken});
    chk({v.name, "_target"}, redir_target, v.exp_target);
    chk({v.name, "_mis"}, {31'd0, redir_misalign}, {31'd0, v.exp_mis});
    chk({v.name, "_target16"}, redir_target16, v.exp_target);
    chk({v.name, "_mis16"}, {31'd0, redir_misalign16}, 32'd0);
    @(negedge clk);
    chk({v.name, "_idle_rdy"}, {31'd0, req_ready}, 32'd1);
    chk({v.name, "_idle_vld"}, {31'd0, redir_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] hold_tgt;
    vecs[0]  = '{"beq",       1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0};
    vecs[1]  = '{"blt",       1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 32'h240, 1'b0};
    vecs[2]  = '{"bltu",      1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0, 32'h204, 1'b0};
    vecs[3]  = '{"f3_010",    1'b1, 1'b0, 1'b0, 3'b010, 32'h7, 32'h7, 32'h300, 32'h40, 1'b0, 32'h304, 1'b0};
    vecs[4]  = '{"jalr_prio", 1'b0, 1'b1, 1'b1, 3'b000, 32'h2001, 32'h0, 32'h500, 32'h4, 1'b1, 32'h2004, 1'b0};
    vecs[5]  = '{"jal_mis",   1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h100, 32'h2, 1'b1, 32'h102, 1'b1};
    vecs[6]  = '{"bne_eq",    1'b1, 1'b0, 1'b0, 3'b001, 32'h5, 32'h5, 32'h10, 32'h80, 1'b0, 32'h14, 1'b0};
    vecs[7]  = '{"bge_neg",   1'b1, 1'b0, 1'b0, 3'b101, 32'h80000000, 32'h0, 32'h20, 32'h80, 1'b0, 32'h24, 1'b0};
    vecs[8]  = '{"bgeu_mis",  1'b1, 1'b0, 1'b0, 3'b111, 32'h80000000, 32'h0, 32'h1000, 32'hFFFFFFFE, 1'b1, 32'hFFE, 1'b1};
    vecs[9]  = '{"noflag",    1'b0, 1'b0, 1'b0, 3'b000, 32'h9, 32'h9, 32'h40, 32'h100, 1'b0, 32'h44, 1'b0};
    vecs[10] = '{"blt_wrap",  1'b1, 1'b0, 1'b0, 3'b100, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4, 1'b0};
    vecs[11] = '{"jalr_wrap", 1'b0, 1'b0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h3, 1'b1, 32'h2, 1'b1};

    rst = 1'b1; req_valid = 1'b0; redir_ready = 1'b1;
    is_b = 1'b0; is_j = 1'b0; is_jr = 1'b0; funct3 = 3'b000;
    src1 = '0; src2 = '0; pc = '0; imm = '0;
`ifdef BRANCH_RESOLVE_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, req_ready}, 32'd1);
    chk("rst_vld", {31'd0, redir_valid}, 32'd0);
    chk("rst_taken", {31'd0, redir_taken}, 32'd0);
    chk("rst_target", redir_target, 32'd0);
    chk("rst_mis", {31'd0, redir_misalign}, 32'd0);

    for (int i = 0; i < 12; i++) send(vecs[i]);

    // Backpressure: result must hold and new requests be ignored.
    hold_tgt = 32'h3000;
    v = '{"hold", 1'b0, 1'b0, 1'b1, 3'b000, 32'h3000, 32'h0, 32'h700, 32'h0, 1'b1, 32'h3000, 1'b0};
    redir_ready = 1'b0;
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      is_b = 1'b0; is_j = 1'b1; is_jr = 1'b0; pc = 32'h8000; imm = 32'h6;
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_vld", {31'd0, redir_valid}, 32'd1);
      chk("hold_rdy", {31'd0, req_ready}, 32'd0);
      chk("hold_taken", {31'd0, redir_taken}, 32'd1);
      chk("hold_target", redir_target, hold_tgt);
      chk("hold_mis", {31'd0, redir_misalign}, 32'd0);
    end
    req_valid = 1'b0;
    redir_ready = 1'b1;
    @(negedge clk);
    chk("release_rdy", {31'd0, req_ready}, 32'd1);
    chk("release_vld", {31'd0, redir_valid}, 32'd0);
    @(negedge clk);
    chk("noaccept_rdy", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset during EVAL, checked before any clock edge.
    drive(vecs[5]);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", {31'd0, req_ready}, 32'd1);
    chk("arst_vld", {31'd0, redir_valid}, 32'd0);
    chk("arst_taken", {31'd0, redir_taken}, 32'd0);
    chk("arst_target", redir_target, 32'd0);
    chk("arst_mis", {31'd0, redir_misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_discard_vld", {31'd0, redir_valid}, 32'd0);
    chk("arst_discard_rdy", {31'd0, req_ready}, 32'd1);
    send(vecs[0]);

`ifdef BRANCH_RESOLVE_PERF_EN
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr0_res", perf_resolved, 32'd0);
    send(vecs[0]);
    send(vecs[2]);
    send(vecs[1]);
    send(vecs[3]);
    send(vecs[5]);
    chk("perf_resolved", perf_resolved, 32'd5);
    chk("perf_taken", perf_taken, 32'd3);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr_res", perf_resolved, 32'd0);
    chk("perf_clr_taken", perf_taken, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
